irq_pending_latch: RTL
======================

Name: irq_pending_latch

Overview:
- Request-capture stage directly upstream of the 8-to-4 priority encoder.
- Edge-detects 8 asynchronous-origin request lines and holds each event as a sticky pending bit until it is acknowledged.
- Applies a per-line mask and drives the masked pending vector into the encoder's 8-bit input.
- The consumer of the encoder output (index 0..7) returns an acknowledge that clears the serviced bit.

Parameters:
- N, 8, number of request lines; the encoder pairing requires 8.
- IDX_W, 3, acknowledge index width; equals clog2(N).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_in  input  N  raw request lines; a rising edge is an event
- mask  input  N  1 = line hidden from pend_vec; the pending state is still kept
- ack_valid  input  1  acknowledge strobe, one cycle per acknowledge
- ack_idx  input  IDX_W  index of the line being acknowledged
- clr_ovf  input  1  clears all overflow bits
- pend_vec  output  N  registered masked pending vector; feeds the encoder input
- pend_any  output  1  registered OR of pend_vec
- pend_cnt  output  4  registered popcount of pend_vec, range 0..8
- ovf  output  N  sticky per-line overflow flags
- ack_err  output  1  one-cycle pulse: acknowledge targeted a non-pending line

Behaviour:
- Reset (asynchronous, rst_n=0):
  - raw_pend = 0, ovf = 0, pend_vec = 0, pend_any = 0, pend_cnt = 0, ack_err = 0.
  - req_d (previous-sample register) resets to all ones, so a line already high at reset release produces no event.
- Edge detect, per bit i at each rising edge:
  - rise[i] = req_in[i] & ~req_d[i].
  - Then req_d <= req_in.
- Clear condition, per bit: clr[i] = ack_valid & (ack_idx == i).
- Next raw_pend[i]:
  - rise=1 -> 1. Set wins over a simultaneous clear; the new event is never lost.
  - rise=0, clr=1 -> 0.
  - otherwise -> hold.
- Overflow:
  - ovf[i] sets when rise[i]=1 and raw_pend[i]=1 and clr[i]=0 (event merged into an existing pending bit).
  - clr_ovf=1 clears all ovf bits. A set in the same cycle as clr_ovf wins.
- Outputs, registered from next-state values:
  - pend_vec <= next_raw_pend & ~mask.
  - pend_any <= |(next_raw_pend & ~mask).
  - pend_cnt <= popcount(next_raw_pend & ~mask), zero-extended to 4 bits.
- Latency: req_in seen high at edge k with req_d low -> pend_vec bit high immediately after edge k.
- Acknowledge latency: ack at edge k -> bit low after edge k.
- Mask behaviour:
  - A mask change is reflected after the next edge.
  - Masked lines still capture events and still record overflow.
  - Unmasking exposes a held pending bit.
  - An acknowledge on a masked but pending line clears it normally.
- ack_err:
  - Pulses 1 for one cycle after edge k if ack_valid=1 and raw_pend[ack_idx]=0 at edge k. No state change.
  - ack_idx values >= N also raise ack_err; this is reachable only when N < 2^IDX_W.
- Multiple simultaneous rises are all captured in the same cycle.
- Only one acknowledge per cycle.
- Reset mid-operation discards all pending events and overflow flags immediately; outputs go to reset values without waiting for clk.

Optional Feature:
- Macro: IRQ_PENDING_LATCH_REQ_SYNC_EN.
- Defined:
  - req_in passes through a 2-flop synchronizer before edge detection.
  - Both stages reset to all ones.
  - Event latency grows by 2 cycles: req_in high before edge k -> pend_vec bit high after edge k+2.
- Undefined:
  - req_in feeds edge detection directly; the latency is as stated in Behaviour.
- Ack, mask and clr_ovf paths are unaffected in both builds.

Test Plan:
1. Reset with req_in=8'hFF held, release rst_n, run 3 cycles -> pend_vec=8'h00, pend_cnt=0, no events; drop req_in to 0, raise bit 5 -> pend_vec=8'h20, pend_any=1, pend_cnt=1.
2. Rise bits 7,3,0 in the same cycle, mask=0 -> pend_vec=8'h89, pend_cnt=3; ack_idx=7 -> 8'h09; ack_idx=3 -> 8'h01; ack_idx=0 -> 8'h00, pend_any=0.
3. Bit 2 pending, second rise on bit 2 without ack -> ovf=8'h04, pend_vec unchanged 8'h04; clr_ovf pulse -> ovf=8'h00.
4. Bit 4 pending, ack_idx=4 in the same cycle as a new rise on bit 4 -> pend_vec stays 8'h10, ovf=8'h00; ack_idx=6 with bit 6 clear -> ack_err pulses one cycle, pend_vec unchanged.
5. mask=8'hF0, rise on bits 6 and 1 -> pend_vec=8'h02, pend_cnt=1; mask=0 -> pend_vec=8'h42, pend_cnt=2.
6. Bits 1 and 7 pending, assert rst_n=0 between clock edges -> all outputs 0 immediately; with IRQ_PENDING_LATCH_REQ_SYNC_EN defined, repeat scenario 1 and check that bit 5 appears 2 cycles later.

Source files
------------

// File: rtl/irq_pending_latch_if.sv
// -----------------------------------------------------------------------------
// irq_pending_latch_if
// Bundles the request/acknowledge/status signals of irq_pending_latch.
//   master : the side that drives requests, mask, acknowledges and clr_ovf
//            and observes the pending/overflow status.
//   slave  : the latch itself.
// Signals:
//   req_in    [N]     raw request lines (rising edge = event)
//   mask      [N]     1 hides a line from pend_vec (pending state kept)
//   ack_valid [1]     one-cycle acknowledge strobe
//   ack_idx   [IDX_W] index of the acknowledged line
//   clr_ovf   [1]     clears all overflow flags
//   pend_vec  [N]     registered masked pending vector (encoder input)
//   pend_any  [1]     registered OR of pend_vec
//   pend_cnt  [4]     registered popcount of pend_vec
//   ovf       [N]     sticky per-line overflow flags
//   ack_err   [1]     one-cycle pulse, acknowledge hit a non-pending line
// -----------------------------------------------------------------------------
interface irq_pending_latch_if #(
  parameter int N     = 8,
  parameter int IDX_W = 3
);
  logic [N-1:0]     req_in;
  logic [N-1:0]     mask;
  logic             ack_valid;
  logic [IDX_W-1:0] ack_idx;
  logic             clr_ovf;
  logic [N-1:0]     pend_vec;
  logic             pend_any;
  logic [3:0]       pend_cnt;
  logic [N-1:0]     ovf;
  logic             ack_err;

  modport master (
    output req_in, mask, ack_valid, ack_idx, clr_ovf,
    input  pend_vec, pend_any, pend_cnt, ovf, ack_err
  );

  modport slave (
    input  req_in, mask, ack_valid, ack_idx, clr_ovf,
    output pend_vec, pend_any, pend_cnt, ovf, ack_err
  );
endinterface

// File: rtl/irq_pending_latch.sv
// -----------------------------------------------------------------------------
// irq_pending_latch
// Request-capture stage in front of the 8-to-4 priority encoder. Rising edges
// on req_in set sticky pending bits; an acknowledge (ack_valid/ack_idx)
// clears the serviced bit. The masked pending vector, its OR and popcount
// are registered from next-state values so a new event shows up right after
// the edge that sees it. A second event on a still-pending line sets the
// sticky ovf flag for that line.
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : irq_pending_latch_if.slave (req_in, mask, ack_valid, ack_idx,
//           clr_ovf in; pend_vec, pend_any, pend_cnt, ovf, ack_err out)
//
// Optional feature (macro IRQ_PENDING_LATCH_REQ_SYNC_EN):
//   defined   -> req_in goes through a 2-flop synchronizer (reset to all ones)
//                before edge detection, adding 2 cycles of event latency.
//   undefined -> req_in feeds edge detection directly.
// -----------------------------------------------------------------------------
module irq_pending_latch #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  irq_pending_latch_if.slave bus
);

  // Popcount of a line vector, zero-extended to the 4-bit count output.
  function automatic logic [3:0] popcount(input logic [N-1:0] v);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < N; i++) begin
      cnt = cnt + {3'd0, v[i]};
    end
    return cnt;
  endfunction

  logic [N-1:0] req_s;        // request vector seen by the edge detector
  logic [N-1:0] req_d_r;      // previous sample of req_s
  logic [N-1:0] raw_pend_r;   // unmasked pending state
  logic [N-1:0] ovf_r;
  logic [N-1:0] rise_s;
  logic [N-1:0] clr_s;
  logic [N-1:0] next_pend_s;
  logic [N-1:0] ovf_set_s;
  logic [N-1:0] next_ovf_s;
  logic [N-1:0] masked_s;
  logic         ack_err_s;
  logic [N-1:0] pend_vec_r;
  logic         pend_any_r;
  logic [3:0]   pend_cnt_r;
  logic         ack_err_r;

`ifdef IRQ_PENDING_LATCH_REQ_SYNC_EN
  logic [N-1:0] sync1_r;
  logic [N-1:0] sync2_r;

  // Two-stage synchronizer; all-ones reset so lines high at release are not events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= {N{1'b1}};
      sync2_r <= {N{1'b1}};
    end else begin
      sync1_r <= bus.req_in;
      sync2_r <= sync1_r;
    end
  end

  assign req_s = sync2_r;
`else
  assign req_s = bus.req_in;
`endif

  assign rise_s = req_s & ~req_d_r;

  // Decode the acknowledge into a one-hot clear; indices >= N decode to nothing.
  always_comb begin
    clr_s = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (bus.ack_valid && (bus.ack_idx == IDX_W'(i))) begin
        clr_s[i] = 1'b1;
      end else begin
        clr_s[i] = 1'b0;
      end
    end
  end

  // A rise always sets the bit, even if the same bit is being acknowledged.
  assign next_pend_s = rise_s | (raw_pend_r & ~clr_s);

  // An event merging into a bit that stays pending is an overflow.
  assign ovf_set_s = rise_s & raw_pend_r & ~clr_s;

  // Overflow next state; a new overflow survives a simultaneous clr_ovf.
  always_comb begin
    if (bus.clr_ovf) begin
      next_ovf_s = ovf_set_s;
    end else begin
      next_ovf_s = ovf_r | ovf_set_s;
    end
  end

  assign masked_s = next_pend_s & ~bus.mask;

  // An empty clr_s/raw_pend_r overlap covers both "not pending" and "index out of range".
  assign ack_err_s = bus.ack_valid & ~(|(raw_pend_r & clr_s));

  // Edge-detect history and pending/overflow state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_d_r    <= {N{1'b1}};
      raw_pend_r <= {N{1'b0}};
      ovf_r      <= {N{1'b0}};
    end else begin
      req_d_r    <= req_s;
      raw_pend_r <= next_pend_s;
      ovf_r      <= next_ovf_s;
    end
  end

  // Registered encoder-facing outputs, taken from next-state values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_vec_r <= {N{1'b0}};
      pend_any_r <= 1'b0;
      pend_cnt_r <= 4'd0;
      ack_err_r  <= 1'b0;
    end else begin
      pend_vec_r <= masked_s;
      pend_any_r <= |masked_s;
      pend_cnt_r <= popcount(masked_s);
      ack_err_r  <= ack_err_s;
    end
  end

  assign bus.pend_vec = pend_vec_r;
  assign bus.pend_any = pend_any_r;
  assign bus.pend_cnt = pend_cnt_r;
  assign bus.ovf      = ovf_r;
  assign bus.ack_err  = ack_err_r;

endmodule
